// File: rtl/filter_run_ctrl.sv
// Run sequencer: primes the filter, gates dp_enable for cmd_len samples, drains, then reports detection stats.
// dp_enable follows smp_valid combinationally in RUN; commands are taken only in IDLE (cmd_ready), abort preempts any active phase.
module filter_run_ctrl #(
  parameter int LEN_W         = 16,
  parameter int FLUSH_SAMPLES = 8,
  parameter int DRAIN_CYCLES  = 6,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_abort,
  input  logic             smp_valid,
  output logic             dp_enable,
  input  logic             detected_in,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] det_count,
  output logic             det_seen,
  output logic [LEN_W-1:0] first_det_idx
);

  localparam int FL_LAST = (FLUSH_SAMPLES > 0) ? FLUSH_SAMPLES - 1 : 0;
  localparam int DR_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
  localparam int FL_W    = (FL_LAST > 0) ? $clog2(FL_LAST + 1) : 1;
  localparam int DR_W    = (DR_LAST > 0) ? $clog2(DR_LAST + 1) : 1;

  typedef enum logic [2:0] {IDLE, FLUSH, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] run_idx_q, run_idx_d;
  logic [LEN_W-1:0] first_det_idx_q, first_det_idx_d;
  logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [DR_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] det_count_q, det_count_d;
  logic             det_prev_q, det_prev_d;
  logic             det_seen_q, det_seen_d;
  logic             aborted_q, aborted_d;
  logic             det_edge;
  logic             det_window;

  assign cmd_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign dp_enable     = (state_q == RUN) & smp_valid & ~cmd_abort;
  assign aborted       = aborted_q;
  assign det_count     = det_count_q;
  assign det_seen      = det_seen_q;
  assign first_det_idx = first_det_idx_q;

  assign det_edge   = detected_in & ~det_prev_q;
  assign det_window = (state_q == RUN) | (state_q == DRAIN);

  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    run_idx_d       = run_idx_q;
    flush_cnt_d     = flush_cnt_q;
    drain_cnt_d     = drain_cnt_q;
    det_count_d     = det_count_q;
    det_seen_d      = det_seen_q;
    first_det_idx_d = first_det_idx_q;
    aborted_d       = aborted_q;
    det_prev_d      = detected_in;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          len_d           = cmd_len;
          run_idx_d       = '0;
          flush_cnt_d     = '0;
          drain_cnt_d     = '0;
          det_count_d     = '0;
          det_seen_d      = 1'b0;
          first_det_idx_d = '0;
          aborted_d       = 1'b0;
          det_prev_d      = 1'b0;
          state_d         = (cmd_len == '0) ? DONE : FLUSH;
        end
      end
      FLUSH: begin
        if (cmd_abort) begin
          aborted_d = 1'b1;
          state_d   = DONE;
        end else if (FLUSH_SAMPLES == 0) begin
          state_d = RUN;
        end else if (smp_valid) begin
          if (flush_cnt_q == FL_W'(FL_LAST)) state_d = RUN;
          else flush_cnt_d = flush_cnt_q + FL_W'(1);
        end
      end
      RUN: begin
        if (cmd_abort) begin
          aborted_d = 1'b1;
          state_d   = DONE;
        end else if (smp_valid) begin
          // run_idx ends at len, which is what a first detection in DRAIN reports
          run_idx_d = run_idx_q + LEN_W'(1);
          if (run_idx_q == len_q - LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cmd_abort) begin
          aborted_d = 1'b1;
          state_d   = DONE;
        end else if ((DRAIN_CYCLES == 0) || (drain_cnt_q == DR_W'(DR_LAST))) begin
          state_d = DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + DR_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (det_window && det_edge) begin
      if (det_count_q != '1) det_count_d = det_count_q + CNT_W'(1);
      if (!det_seen_q) begin
        det_seen_d      = 1'b1;
        first_det_idx_d = run_idx_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      len_q           <= '0;
      run_idx_q       <= '0;
      flush_cnt_q     <= '0;
      drain_cnt_q     <= '0;
      det_count_q     <= '0;
      det_seen_q      <= 1'b0;
      first_det_idx_q <= '0;
      aborted_q       <= 1'b0;
      det_prev_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      run_idx_q       <= run_idx_d;
      flush_cnt_q     <= flush_cnt_d;
      drain_cnt_q     <= drain_cnt_d;
      det_count_q     <= det_count_d;
      det_seen_q      <= det_seen_d;
      first_det_idx_q <= first_det_idx_d;
      aborted_q       <= aborted_d;
      det_prev_q      <= det_prev_d;
    end
  end

endmodule

// File: tb/tb_filter_run_ctrl.sv
// Bench for filter_run_ctrl: per-cycle stimulus tables per run, checked against a run-level model.
module tb_filter_run_ctrl;
  localparam int LEN_W = 16;
  localparam int CNT_W = 16;
  localparam int FLUSH = 8;
  localparam int DRAIN = 6;
  localparam int N     = 512;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid, cmd_ready, cmd_abort, smp_valid, dp_enable, detected_in;
  logic             busy, done, aborted, det_seen;
  logic [LEN_W-1:0] cmd_len, first_det_idx;
  logic [CNT_W-1:0] det_count;

  int checks = 0;
  int errors = 0;

  filter_run_ctrl #(.LEN_W(LEN_W), .FLUSH_SAMPLES(FLUSH), .DRAIN_CYCLES(DRAIN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .cmd_abort(cmd_abort), .smp_valid(smp_valid), .dp_enable(dp_enable), .detected_in(detected_in),
    .busy(busy), .done(done), .aborted(aborted), .det_count(det_count), .det_seen(det_seen),
    .first_det_idx(first_det_idx)
  );

  always #5 clk = ~clk;

  // per-cycle stimulus of one run; cycle 0 is the accept cycle
  logic             sv [N];
  logic             dt [N];
  logic             ab [N];
  logic             cv [N];
  logic [LEN_W-1:0] len_in;

  logic [N-1:0] en_exp, en_obs, busy_exp, busy_obs, rdy_obs;
  int           done_exp, done_obs, done_pulses;
  int           cnt_exp, idx_exp;
  logic         seen_exp, ab_exp;

  task automatic clear_stim(input logic [LEN_W-1:0] len);
    for (int i = 0; i < N; i++) begin
      sv[i] = 1'b0; dt[i] = 1'b0; ab[i] = 1'b0; cv[i] = 1'b0;
    end
    cv[0]  = 1'b1;
    len_in = len;
  endtask

  // Run-level expectation: 8th valid sample ends priming, the next len valid samples are enabled,
  // done lands DRAIN+1 cycles after the last one; an abort in an active phase ends it one cycle later.
  task automatic model_run();
    int f, k, e, a_c;
    en_exp = '0; busy_exp = '0;
    cnt_exp = 0; idx_exp = 0; seen_exp = 1'b0; ab_exp = 1'b0;
    a_c = -1;
    for (int c = 1; c < N; c++) if (ab[c] && a_c < 0) a_c = c;
    if (len_in == 0) begin
      done_exp = 1;
    end else begin
      f = -1; k = 0;
      for (int c = 1; c < N; c++) if (sv[c] && f < 0) begin
        k++;
        if (k == FLUSH) f = c;
      end
      k = 0; e = -1;
      for (int c = f + 1; c < N; c++) if (sv[c] && k < int'(len_in)) begin
        en_exp[c] = 1'b1;
        k++;
        if (k == int'(len_in)) e = c;
      end
      done_exp = e + DRAIN + 1;
      if (a_c >= 1 && a_c < done_exp) begin
        done_exp = a_c + 1;
        ab_exp   = 1'b1;
        for (int c = a_c; c < N; c++) en_exp[c] = 1'b0;
      end
      for (int c = f + 1; c < done_exp; c++) if (dt[c] && !dt[c-1]) begin
        cnt_exp++;
        if (!seen_exp) begin
          seen_exp = 1'b1;
          for (int j = 0; j < c; j++) idx_exp += int'(en_exp[j]);
        end
      end
    end
    for (int c = 1; c <= done_exp; c++) busy_exp[c] = 1'b1;
  endtask

  task automatic apply_run(input int ncyc);
    en_obs = '0; busy_obs = '0; rdy_obs = '0; done_obs = -1; done_pulses = 0;
    for (int c = 0; c < ncyc; c++) begin
      cmd_valid = cv[c]; cmd_len = len_in; smp_valid = sv[c]; detected_in = dt[c]; cmd_abort = ab[c];
      @(negedge clk);
      en_obs[c] = dp_enable; busy_obs[c] = busy; rdy_obs[c] = cmd_ready;
      if (done) begin
        done_pulses++;
        if (done_obs < 0) done_obs = c;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0; smp_valid = 1'b0; detected_in = 1'b0; cmd_abort = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; cmd_valid = 1'b0; cmd_len = '0; cmd_abort = 1'b0; smp_valid = 1'b0; detected_in = 1'b0;
    #12;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
    checks++; if ({dp_enable, busy, done, aborted, det_seen} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {dp_enable, busy, done, aborted, det_seen}); end
    checks++; if (det_count !== '0 || first_det_idx !== '0) begin errors++; $display("FAIL reset_stats got cnt %0d idx %0d exp 0 0", det_count, first_det_idx); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [N-1:0] lit;
    clear_stim(5);
    for (int c = 0; c < N; c++) sv[c] = 1'b1;
    model_run();
    apply_run(done_exp + 3);
    lit = {{(N-5){1'b0}}, 5'b11111} << 9;
    checks++; if (en_obs !== lit) begin errors++; $display("FAIL basic_enable got %h exp %h", en_obs, lit); end
    checks++; if (done_obs !== 20) begin errors++; $display("FAIL basic_done_cycle got %0d exp 20", done_obs); end
    checks++; if (done_pulses !== 1) begin errors++; $display("FAIL basic_done_pulses got %0d exp 1", done_pulses); end
    checks++; if (busy_obs !== busy_exp) begin errors++; $display("FAIL basic_busy got %h exp %h", busy_obs, busy_exp); end
    checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL basic_aborted got %b exp 0", aborted); end
  endtask

  task automatic test_toggle();
    clear_stim(4);
    for (int c = 0; c < N; c++) sv[c] = (c % 2 == 1);
    model_run();
    apply_run(done_exp + 3);
    checks++; if (en_obs !== en_exp) begin errors++; $display("FAIL toggle_enable got %h exp %h", en_obs, en_exp); end
    checks++; if ($countones(en_obs) !== 4) begin errors++; $display("FAIL toggle_pulses got %0d exp 4", $countones(en_obs)); end
    checks++; if (done_obs !== 30) begin errors++; $display("FAIL toggle_done_cycle got %0d exp 30", done_obs); end
  endtask

  task automatic test_detect();
    clear_stim(4);
    for (int c = 0; c < N; c++) sv[c] = 1'b1;
    dt[0] = 1'b1; dt[3] = 1'b1;
    dt[11] = 1'b1; dt[12] = 1'b1; dt[13] = 1'b1;
    dt[15] = 1'b1; dt[19] = 1'b1;
    model_run();
    apply_run(done_exp + 3);
    checks++; if (det_count !== CNT_W'(2)) begin errors++; $display("FAIL detect_count got %0d exp 2", det_count); end
    checks++; if (det_seen !== 1'b1) begin errors++; $display("FAIL detect_seen got %b exp 1", det_seen); end
    checks++; if (first_det_idx !== LEN_W'(2)) begin errors++; $display("FAIL detect_first_idx got %0d exp 2", first_det_idx); end
    checks++; if (done_obs !== 19) begin errors++; $display("FAIL detect_done_cycle got %0d exp 19", done_obs); end
  endtask

  task automatic test_abort();
    clear_stim(10);
    for (int c = 0; c < N; c++) sv[c] = 1'b1;
    ab[10] = 1'b1; dt[10] = 1'b1;
    model_run();
    apply_run(done_exp + 3);
    checks++; if ($countones(en_obs) !== 1 || en_obs[9] !== 1'b1) begin errors++; $display("FAIL abort_enable got %h exp only cycle 9", en_obs); end
    checks++; if (done_obs !== 11) begin errors++; $display("FAIL abort_done_cycle got %0d exp 11", done_obs); end
    checks++; if (aborted !== 1'b1) begin errors++; $display("FAIL abort_flag got %b exp 1", aborted); end
    checks++; if (det_count !== CNT_W'(1) || first_det_idx !== LEN_W'(1)) begin errors++; $display("FAIL abort_det got cnt %0d idx %0d exp 1 1", det_count, first_det_idx); end
    clear_stim(3);
    for (int c = 0; c < N; c++) sv[c] = 1'b1;
    ab[0] = 1'b1;
    model_run();
    apply_run(done_exp + 3);
    checks++; if ($countones(en_obs) !== 3) begin errors++; $display("FAIL idle_abort_pulses got %0d exp 3", $countones(en_obs)); end
    checks++; if (done_obs !== 18 || aborted !== 1'b0) begin errors++; $display("FAIL idle_abort_done got cycle %0d aborted %b exp 18 0", done_obs, aborted); end
  endtask

  task automatic test_zero_len();
    clear_stim(0);
    for (int c = 0; c < N; c++) sv[c] = 1'b1;
    cv[1] = 1'b1; cv[2] = 1'b1; dt[1] = 1'b1;
    apply_run(6);
    checks++; if (en_obs !== '0) begin errors++; $display("FAIL zero_enable got %h exp 0", en_obs); end
    checks++; if (done_obs !== 1 || done_pulses !== 2) begin errors++; $display("FAIL zero_done got first %0d pulses %0d exp 1 2", done_obs, done_pulses); end
    checks++; if (rdy_obs[5:0] !== 6'b110101) begin errors++; $display("FAIL zero_cmd_ready got %b exp 110101", rdy_obs[5:0]); end
    checks++; if (busy_obs[5:0] !== 6'b001010) begin errors++; $display("FAIL zero_busy got %b exp 001010", busy_obs[5:0]); end
    checks++; if (det_count !== '0 || det_seen !== 1'b0 || first_det_idx !== '0 || aborted !== 1'b0) begin errors++; $display("FAIL zero_stats got cnt %0d seen %b idx %0d ab %b exp all 0", det_count, det_seen, first_det_idx, aborted); end
  endtask

  task automatic test_random();
    int pct, dens;
    for (int r = 0; r < 25; r++) begin
      clear_stim(($urandom_range(0, 9) == 0) ? LEN_W'(0) : LEN_W'($urandom_range(1, 20)));
      pct  = $urandom_range(30, 100);
      dens = $urandom_range(0, 40);
      for (int c = 0; c < N; c++) begin
        sv[c] = (c > 200) ? 1'b1 : ($urandom_range(0, 99) < pct);
        dt[c] = ($urandom_range(0, 99) < dens);
      end
      if ($urandom_range(0, 3) == 0) ab[$urandom_range(0, 60)] = 1'b1;
      model_run();
      apply_run(done_exp + 3);
      checks++; if (en_obs !== en_exp) begin errors++; $display("FAIL rand%0d_enable got %h exp %h", r, en_obs, en_exp); end
      checks++; if (busy_obs !== busy_exp) begin errors++; $display("FAIL rand%0d_busy got %h exp %h", r, busy_obs, busy_exp); end
      checks++; if (done_obs !== done_exp || done_pulses !== 1) begin errors++; $display("FAIL rand%0d_done got cycle %0d pulses %0d exp %0d 1", r, done_obs, done_pulses, done_exp); end
      checks++; if (aborted !== ab_exp) begin errors++; $display("FAIL rand%0d_aborted got %b exp %b", r, aborted, ab_exp); end
      checks++; if (det_count !== CNT_W'(cnt_exp)) begin errors++; $display("FAIL rand%0d_det_count got %0d exp %0d", r, det_count, cnt_exp); end
      checks++; if (det_seen !== seen_exp || first_det_idx !== LEN_W'(idx_exp)) begin errors++; $display("FAIL rand%0d_first got seen %b idx %0d exp %b %0d", r, det_seen, first_det_idx, seen_exp, idx_exp); end
    end
  endtask

  task automatic test_async_reset();
    clear_stim(10);
    for (int c = 0; c < N; c++) sv[c] = 1'b1;
    dt[10] = 1'b1;
    apply_run(13);
    smp_valid = 1'b1;
    #2;
    checks++; if (dp_enable !== 1'b1 || det_count !== CNT_W'(1)) begin errors++; $display("FAIL areset_pre got en %b cnt %0d exp 1 1", dp_enable, det_count); end
    reset = 1'b0;
    #1;
    checks++; if (dp_enable !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL areset_ctrl got en %b busy %b rdy %b exp 0 0 1", dp_enable, busy, cmd_ready); end
    checks++; if (det_count !== '0 || det_seen !== 1'b0 || first_det_idx !== '0) begin errors++; $display("FAIL areset_stats got cnt %0d seen %b idx %0d exp 0 0 0", det_count, det_seen, first_det_idx); end
    #2;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || dp_enable !== 1'b0) begin errors++; $display("FAIL areset_post got rdy %b busy %b en %b exp 1 0 0", cmd_ready, busy, dp_enable); end
    smp_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle();
    test_detect();
    test_abort();
    test_zero_len();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
